// File: rtl/machine_timer_pkg.sv
// Shared constants and helpers for the memory-mapped machine timer.
// Register offsets are in 32-bit words from the window base.
package machine_timer_pkg;

  localparam int unsigned OFF_MTIME_LO = 0;
  localparam int unsigned OFF_MTIME_HI = 1;
  localparam int unsigned OFF_CMP_BASE = 2;

  localparam logic [63:0] MTIMECMP_RESET = 64'hffff_ffff_ffff_ffff;
  // Enable set, divisor zero.
  localparam logic [31:0] CTRL_RESET = 32'h0000_0001;

  function automatic int unsigned ctrl_offset(input int unsigned num_cmp);
    return OFF_CMP_BASE + 2 * num_cmp;
  endfunction

  function automatic int unsigned window_words(input int unsigned num_cmp);
    return ctrl_offset(num_cmp) + 1;
  endfunction

  // Byte-lane merge: [0] covers 7:0, [1] covers 15:8, [2] covers 31:16.
  function automatic logic [31:0] apply_sections(input logic [31:0] old_value,
                                                 input logic [31:0] new_value,
                                                 input logic [2:0]  sections);
    logic [31:0] merged;
    merged = old_value;
    if (sections[0]) merged[7:0]   = new_value[7:0];
    if (sections[1]) merged[15:8]  = new_value[15:8];
    if (sections[2]) merged[31:16] = new_value[31:16];
    return merged;
  endfunction

endpackage

// File: rtl/machine_timer_if.sv
// Core data-port view of the machine timer: address/write in, registered read and irqs out.
interface machine_timer_if #(
  parameter int NUM_CMP = 1
);
  logic [31:0]        memory_address;
  logic [31:0]        memory_write_value;
  logic [2:0]         memory_write_sections;
  logic [31:0]        read_value;
  logic               read_hit;
  logic [NUM_CMP-1:0] timer_irq;

  modport master (
    output memory_address, memory_write_value, memory_write_sections,
    input  read_value, read_hit, timer_irq
  );

  modport slave (
    input  memory_address, memory_write_value, memory_write_sections,
    output read_value, read_hit, timer_irq
  );
endinterface

// File: rtl/machine_timer_compare.sv
// One mtimecmp channel: strobed 64-bit compare register and a registered
// unsigned mtime >= mtimecmp interrupt.
module timer_compare
  import machine_timer_pkg::*;
(
  input  logic        clk24,
  input  logic        rst_n,
  input  logic [63:0] mtime,
  input  logic        write_lo,
  input  logic        write_hi,
  input  logic [31:0] write_value,
  input  logic [2:0]  write_sections,
  output logic [63:0] mtimecmp,
  output logic        irq
);

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp <= MTIMECMP_RESET;
    end else begin
      if (write_lo) mtimecmp[31:0]  <= apply_sections(mtimecmp[31:0], write_value, write_sections);
      if (write_hi) mtimecmp[63:32] <= apply_sections(mtimecmp[63:32], write_value, write_sections);
    end
  end

  // Level output from registered operands, so it drops as soon as the compare no longer holds.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= (mtime >= mtimecmp);
  end

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: prescaled 64-bit mtime, NUM_CMP compare channels,
// torn-read-free MTIME hi via a shadow captured on MTIME lo reads.
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int          NUM_CMP        = 1,
  parameter logic [31:0] BASE_ADDRESS   = 32'h8000_0000,
  parameter int          PRESCALE_WIDTH = 8
) (
  input  logic            clk24,
  input  logic            rst_n,
  machine_timer_if.slave  bus
);

  localparam logic [29:0] WORD_MTIME_LO = 30'(OFF_MTIME_LO);
  localparam logic [29:0] WORD_MTIME_HI = 30'(OFF_MTIME_HI);
  localparam logic [29:0] WORD_CTRL     = 30'(ctrl_offset(NUM_CMP));
  localparam logic [31:0] WINDOW_BYTES  = 32'(window_words(NUM_CMP) * 4);
  localparam logic [31:0] DIVISOR_MASK  = 32'(((64'd1 << PRESCALE_WIDTH) - 64'd1) << 8);
  localparam logic [31:0] CTRL_MASK     = DIVISOR_MASK | 32'd1;

  logic [31:0]               rel_address;
  logic [29:0]               word;
  logic                      in_window;
  logic                      write_any;
  logic                      write_mtime_lo;
  logic                      write_mtime_hi;
  logic                      write_ctrl;
  logic                      snapshot;

  logic [63:0]               mtime;
  logic [PRESCALE_WIDTH-1:0] prescale_count;
  logic [31:0]               ctrl;
  logic [31:0]               ctrl_next;
  logic                      divisor_change;
  logic                      enable;
  logic [PRESCALE_WIDTH-1:0] divisor;
  logic [31:0]               shadow;

  logic [63:0]               cmp_value [NUM_CMP];
  logic [NUM_CMP-1:0]        irq;

  logic [31:0]               read_next;
  logic [31:0]               read_value;
  logic                      read_hit;

  // Unsigned subtraction wraps addresses below the base to large offsets, outside the window.
  assign rel_address    = bus.memory_address - BASE_ADDRESS;
  assign word           = rel_address[31:2];
  assign in_window      = rel_address < WINDOW_BYTES;
  assign write_any      = in_window && (bus.memory_write_sections != 3'b000);
  assign write_mtime_lo = write_any && (word == WORD_MTIME_LO);
  assign write_mtime_hi = write_any && (word == WORD_MTIME_HI);
  assign write_ctrl     = write_any && (word == WORD_CTRL);
  assign snapshot       = in_window && (word == WORD_MTIME_LO) && (bus.memory_write_sections == 3'b000);

  assign enable         = ctrl[0];
  assign divisor        = ctrl[8 +: PRESCALE_WIDTH];
  assign ctrl_next      = apply_sections(ctrl, bus.memory_write_value, bus.memory_write_sections) & CTRL_MASK;
  assign divisor_change = write_ctrl && (((ctrl_next ^ ctrl) & DIVISOR_MASK) != 32'd0);

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n)          ctrl <= CTRL_RESET;
    else if (write_ctrl) ctrl <= ctrl_next;
  end

  // A software write to mtime wins over the tick and restarts the prescale period.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      mtime          <= 64'd0;
      prescale_count <= '0;
    end else if (write_mtime_lo) begin
      mtime[31:0]    <= apply_sections(mtime[31:0], bus.memory_write_value, bus.memory_write_sections);
      prescale_count <= '0;
    end else if (write_mtime_hi) begin
      mtime[63:32]   <= apply_sections(mtime[63:32], bus.memory_write_value, bus.memory_write_sections);
      prescale_count <= '0;
    end else begin
      if (enable) begin
        if (prescale_count == divisor) begin
          mtime          <= mtime + 64'd1;
          prescale_count <= '0;
        end else begin
          prescale_count <= prescale_count + 1'b1;
        end
      end
      if (divisor_change) prescale_count <= '0;
    end
  end

  // MTIME hi reads the shadow, so a hi write must land there to read back.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n)              shadow <= 32'd0;
    else if (write_mtime_hi) shadow <= apply_sections(mtime[63:32], bus.memory_write_value,
                                                      bus.memory_write_sections);
    else if (snapshot)       shadow <= mtime[63:32];
  end

  for (genvar k = 0; k < NUM_CMP; k++) begin : g_cmp
    timer_compare u_compare (
      .clk24          (clk24),
      .rst_n          (rst_n),
      .mtime          (mtime),
      .write_lo       (write_any && (word == 30'(OFF_CMP_BASE + 2 * k))),
      .write_hi       (write_any && (word == 30'(OFF_CMP_BASE + 2 * k + 1))),
      .write_value    (bus.memory_write_value),
      .write_sections (bus.memory_write_sections),
      .mtimecmp       (cmp_value[k]),
      .irq            (irq[k])
    );
  end

  always_comb begin
    read_next = 32'd0;
    if (in_window) begin
      if (word == WORD_MTIME_LO)      read_next = mtime[31:0];
      else if (word == WORD_MTIME_HI) read_next = shadow;
      else if (word == WORD_CTRL)     read_next = ctrl;
      for (int k = 0; k < NUM_CMP; k++) begin
        if (word == 30'(OFF_CMP_BASE + 2 * k))     read_next = cmp_value[k][31:0];
        if (word == 30'(OFF_CMP_BASE + 2 * k + 1)) read_next = cmp_value[k][63:32];
      end
    end
  end

  // Read stage: one-cycle latency to line up with block RAM on the core read mux.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      read_value <= 32'd0;
      read_hit   <= 1'b0;
    end else begin
      read_value <= read_next;
      read_hit   <= in_window;
    end
  end

  assign bus.read_value = read_value;
  assign bus.read_hit   = read_hit;
  assign bus.timer_irq  = irq;

endmodule

// File: tb/tb_machine_timer.sv
// Directed plus randomized bench for machine_timer against a cycle-level
// behavioural model of the register window.
module tb_machine_timer;
  localparam int          NUM_CMP  = 2;
  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam int          PW       = 8;
  localparam int          CTRL_OFF = 2 + 2 * NUM_CMP;

  logic clk24 = 1'b0;
  logic rst_n = 1'b0;

  machine_timer_if #(.NUM_CMP(NUM_CMP)) bus ();

  machine_timer #(
    .NUM_CMP        (NUM_CMP),
    .BASE_ADDRESS   (BASE),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk24 (clk24),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk24 = ~clk24;

  int checks   = 0;
  int failures = 0;

  bit [63:0]   m_time;
  int unsigned m_cnt;
  int unsigned m_div;
  bit          m_en;
  bit [63:0]   m_cmp [NUM_CMP];
  bit [31:0]   m_shadow;
  logic [31:0] obs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old_v, input bit [31:0] new_v, input bit [2:0] sec);
    bit [31:0] mask;
    mask = 32'h0;
    if (sec[0]) mask = mask | 32'h0000_00ff;
    if (sec[1]) mask = mask | 32'h0000_ff00;
    if (sec[2]) mask = mask | 32'hffff_0000;
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic model_reset();
    m_time   = 64'd0;
    m_cnt    = 0;
    m_div    = 0;
    m_en     = 1'b1;
    m_shadow = 32'd0;
    for (int k = 0; k < NUM_CMP; k++) m_cmp[k] = {64{1'b1}};
  endtask

  // One bus cycle: predict the registered outputs, advance the model, then compare.
  task automatic cycle(input bit [31:0] addr, input bit [31:0] wdata, input bit [2:0] sec);
    bit [31:0]          off;
    bit                 hit;
    bit                 wr;
    bit [31:0]          exp_rv;
    bit [NUM_CMP-1:0]   exp_irq;
    bit [63:0]          t_pre;
    bit [31:0]          ctrl_new;
    int                 idx;
    bus.memory_address        = addr;
    bus.memory_write_value    = wdata;
    bus.memory_write_sections = sec;
    off    = (addr - BASE) >> 2;
    hit    = off < 32'(CTRL_OFF + 1);
    wr     = hit && (sec != 3'b000);
    idx    = int'((off - 32'd2) >> 1);
    exp_rv = 32'd0;
    if (hit) begin
      if (off == 0)                  exp_rv = m_time[31:0];
      else if (off == 1)             exp_rv = m_shadow;
      else if (off == 32'(CTRL_OFF)) exp_rv = (m_div << 8) | 32'(m_en);
      else if (off[0])               exp_rv = m_cmp[idx][63:32];
      else                           exp_rv = m_cmp[idx][31:0];
    end
    for (int k = 0; k < NUM_CMP; k++) exp_irq[k] = (m_time >= m_cmp[k]);

    t_pre = m_time;
    if (wr && off == 0) begin
      m_time[31:0] = merge(m_time[31:0], wdata, sec);
      m_cnt = 0;
    end else if (wr && off == 1) begin
      m_time[63:32] = merge(m_time[63:32], wdata, sec);
      m_shadow = m_time[63:32];
      m_cnt = 0;
    end else if (m_en) begin
      if (m_cnt == m_div) begin
        m_time = m_time + 64'd1;
        m_cnt  = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (hit && off == 0 && sec == 3'b000) m_shadow = t_pre[63:32];
    if (wr && off == 32'(CTRL_OFF)) begin
      ctrl_new = merge((m_div << 8) | 32'(m_en), wdata, sec);
      m_en = ctrl_new[0];
      if (((ctrl_new >> 8) & ((32'd1 << PW) - 1)) != m_div) begin
        m_div = (ctrl_new >> 8) & ((32'd1 << PW) - 1);
        m_cnt = 0;
      end
    end
    if (wr && off >= 2 && off < 32'(CTRL_OFF)) begin
      if (off[0]) m_cmp[idx][63:32] = merge(m_cmp[idx][63:32], wdata, sec);
      else        m_cmp[idx][31:0]  = merge(m_cmp[idx][31:0], wdata, sec);
    end

    @(posedge clk24);
    #1;
    obs = bus.read_value;
    check("read_value", bus.read_value, 64'(exp_rv));
    check("read_hit", 64'(bus.read_hit), 64'(hit));
    check("timer_irq", 64'(bus.timer_irq), 64'(exp_irq));
  endtask

  task automatic wr_reg(input int off, input bit [31:0] val);
    cycle(BASE + 32'(off) * 32'd4, val, 3'b111);
  endtask

  task automatic rd_reg(input int off);
    cycle(BASE + 32'(off) * 32'd4, 32'd0, 3'b000);
  endtask

  task automatic idle();
    cycle(32'h0000_0000, 32'd0, 3'b000);
  endtask

  initial begin
    logic [31:0] v0;
    int          first_rise;
    bit          irq0_seen;
    bit [31:0]   addr;
    bit [2:0]    sec;

    bus.memory_address        = 32'd0;
    bus.memory_write_value    = 32'd0;
    bus.memory_write_sections = 3'b000;
    model_reset();
    repeat (2) @(posedge clk24);
    #1;
    check("reset_read_value", 64'(bus.read_value), 64'd0);
    check("reset_read_hit", 64'(bus.read_hit), 64'd0);
    check("reset_timer_irq", 64'(bus.timer_irq), 64'd0);
    rst_n = 1'b1;

    rd_reg(0);
    check("first_mtime_lo", 64'(obs), 64'd0);
    rd_reg(3);
    check("cmp0_hi_reset", 64'(obs), 64'hffff_ffff);

    // Divisor 3: one tick per four cycles.
    wr_reg(CTRL_OFF, 32'h0000_0301);
    rd_reg(0);
    v0 = obs;
    repeat (40) idle();
    rd_reg(0);
    check("prescale_advance", 64'(obs - v0), 64'd10);

    wr_reg(CTRL_OFF, 32'h0000_0001);
    wr_reg(2, 32'hffff_ffff);
    wr_reg(3, 32'hffff_ffff);
    wr_reg(4, 32'd20);
    wr_reg(5, 32'd0);
    wr_reg(1, 32'd0);
    wr_reg(0, 32'd0);
    first_rise = -1;
    irq0_seen  = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      idle();
      if (bus.timer_irq[1] && first_rise < 0) first_rise = i;
      if (bus.timer_irq[0]) irq0_seen = 1'b1;
    end
    check("irq1_rise_cycle", 64'(first_rise), 64'd21);
    check("irq0_stays_low", 64'(irq0_seen), 64'd0);

    wr_reg(1, 32'd0);
    wr_reg(0, 32'hffff_fffe);
    rd_reg(0);
    repeat (5) idle();
    rd_reg(1);
    check("shadow_hi_stale", 64'(obs), 64'd0);
    rd_reg(0);
    rd_reg(1);
    check("shadow_hi_fresh", 64'(obs), 64'd1);

    wr_reg(2, 32'd5);
    wr_reg(3, 32'd0);
    wr_reg(1, 32'hffff_ffff);
    wr_reg(0, 32'hffff_ffff);
    rd_reg(0);
    check("wrap_lo_before", 64'(obs), 64'hffff_ffff);
    check("wrap_irq_pending", 64'(bus.timer_irq), 64'd3);
    rd_reg(0);
    check("wrap_lo_after", 64'(obs), 64'd0);
    check("wrap_irq_clear", 64'(bus.timer_irq), 64'd0);

    // Reset in the middle of a divide-by-8 period with interrupts pending.
    wr_reg(CTRL_OFF, 32'h0000_0701);
    wr_reg(0, 32'd100);
    repeat (3) idle();
    rd_reg(CTRL_OFF);
    check("ctrl_readback", 64'(obs), 64'h701);
    check("irq_before_reset", 64'(bus.timer_irq), 64'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_read_value", 64'(bus.read_value), 64'd0);
    check("async_reset_read_hit", 64'(bus.read_hit), 64'd0);
    check("async_reset_timer_irq", 64'(bus.timer_irq), 64'd0);
    repeat (2) @(posedge clk24);
    #1;
    rst_n = 1'b1;
    model_reset();
    rd_reg(0);
    check("restart_lo0", 64'(obs), 64'd0);
    rd_reg(0);
    check("restart_lo1", 64'(obs), 64'd1);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = BASE - 32'd4;
        default: addr = BASE + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
      endcase
      sec = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      cycle(addr, $urandom, sec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
